// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg
// Shared definitions for the ALU sharing arbiter:
//   - ALU mode codes (the ALU's own encoding)
//   - operand / result / mode widths
//   - in-flight tag layout
//   - helper that flags modes the ALU does not support
package alu_share_arbiter_pkg;

  localparam int OPW   = 8;   // signed operand width
  localparam int RESW  = 16;  // signed result width
  localparam int MODEW = 3;   // mode code width

  typedef enum logic [MODEW-1:0] {
    MODE_ADD       = 3'd0,
    MODE_SUB       = 3'd1,
    MODE_MULT      = 3'd2,
    MODE_DIV       = 3'd3,
    MODE_SHIFTUP   = 3'd4,
    MODE_SHIFTDOWN = 3'd5
  } mode_e;

  // Tag of the single operation inside the ALU. The owner id is not stored
  // here: it always equals the arbiter's last_grant register (see top).
  typedef struct packed {
    logic valid;
    logic err;
  } tag_t;

  // DIV and the undefined codes 6/7 produce an error response.
  function automatic logic mode_is_err(input logic [MODEW-1:0] mode);
    case (mode)
      MODE_ADD, MODE_SUB, MODE_MULT, MODE_SHIFTUP, MODE_SHIFTDOWN: return 1'b0;
      default:                                                   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
// Groups the requester handshake, response slots and ALU drive/return
// signals of one alu_share_arbiter.
//   slave  : the arbiter side (accepts requests, drives responses and ALU)
//   master : requesters plus the ALU (drive requests, consume responses)
interface alu_share_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ-1:0]    req_ready_o;
  logic [8*NREQ-1:0]  req_op1_i;
  logic [8*NREQ-1:0]  req_op2_i;
  logic [3*NREQ-1:0]  req_mode_i;
  logic [NREQ-1:0]    rsp_valid_o;
  logic [NREQ-1:0]    rsp_ready_i;
  logic [16*NREQ-1:0] rsp_res_o;
  logic [NREQ-1:0]    rsp_err_o;
  logic [7:0]         alu_op1_o;
  logic [7:0]         alu_op2_o;
  logic [2:0]         alu_mode_o;
  logic               alu_valid_o;
  logic [15:0]        alu_res_i;
  logic               alu_valid_i;

  modport slave (
    input  req_valid_i, req_op1_i, req_op2_i, req_mode_i, rsp_ready_i,
    input  alu_res_i, alu_valid_i,
    output req_ready_o, rsp_valid_o, rsp_res_o, rsp_err_o,
    output alu_op1_o, alu_op2_o, alu_mode_o, alu_valid_o
  );

  modport master (
    output req_valid_i, req_op1_i, req_op2_i, req_mode_i, rsp_ready_i,
    output alu_res_i, alu_valid_i,
    input  req_ready_o, rsp_valid_o, rsp_res_o, rsp_err_o,
    input  alu_op1_o, alu_op2_o, alu_mode_o, alu_valid_o
  );

endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter. Search starts at last_grant+1 (mod NREQ); last_grant
// resets to NREQ-1 so requester 0 wins first, and moves only on advance.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   eligible     requesters allowed to win this cycle
//   advance      a grant is being taken this cycle
//   grant        one-hot (or zero) winner, combinational
//   last_grant   index of the most recent winner (registered)
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] eligible,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  last_grant
);

  logic [IDW-1:0] last_grant_reg;
  logic [IDW-1:0] last_grant_next;

  always_comb begin
    grant = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(last_grant_reg) + k) % NREQ;
      if (grant == '0 && eligible[idx]) begin
        grant[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    last_grant_next = last_grant_reg;
    if (advance) begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i]) begin
          last_grant_next = IDW'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= IDW'(NREQ - 1);
    end else begin
      last_grant_reg <= last_grant_next;
    end
  end

  assign last_grant = last_grant_reg;

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one fixed-point ALU (1-cycle registered latency) among NREQ
// requesters. Accepts at most one request per cycle by round-robin, drives
// the ALU inputs from the winner, tags the in-flight operation and writes the
// ALU result into that requester's response slot (valid/ready).
// Ports:
//   clk, rst  clock, synchronous active-high reset (shared with the ALU)
//   bus       alu_share_arbiter_if.slave: request handshake + payload,
//             response slots, ALU operand/mode/valid drive and result return
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_share_arbiter_if.slave   bus
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  in_flight;
  logic [IDW-1:0]   last_grant;

  logic [OPW-1:0]   alu_op1;
  logic [OPW-1:0]   alu_op2;
  logic [MODEW-1:0] alu_mode;

  tag_t             tag_reg;
  tag_t             tag_next;
  logic             capture;

  logic [NREQ-1:0]  rsp_valid_reg;
  logic [NREQ-1:0]  rsp_err_reg;
  logic [RESW-1:0]  rsp_res_reg [NREQ];
  logic [16*NREQ-1:0] rsp_res_flat;

  // A valid tag means the ALU holds an operation granted last cycle, so its
  // owner is exactly last_grant (which only moves on a grant).
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
      assign in_flight[gi] = tag_reg.valid && (last_grant == IDW'(gi));
      // Slot is free if empty or being drained this very cycle. Nothing is
      // granted while reset is held so every output reads 0.
      assign eligible[gi]  = !rst && bus.req_valid_i[gi] && !in_flight[gi] &&
                             (!rsp_valid_reg[gi] || bus.rsp_ready_i[gi]);
    end
  endgenerate

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .clk        (clk),
    .rst        (rst),
    .eligible   (eligible),
    .advance    (|grant),
    .grant      (grant),
    .last_grant (last_grant)
  );

  // Payload mux from the one-hot grant; all zero when nothing is granted.
  always_comb begin
    alu_op1  = '0;
    alu_op2  = '0;
    alu_mode = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        alu_op1  = bus.req_op1_i[8*i +: 8];
        alu_op2  = bus.req_op2_i[8*i +: 8];
        alu_mode = bus.req_mode_i[3*i +: 3];
      end
    end
  end

  assign bus.req_ready_o = grant;
  assign bus.alu_op1_o   = alu_op1;
  assign bus.alu_op2_o   = alu_op2;
  assign bus.alu_mode_o  = alu_mode;
  assign bus.alu_valid_o = |grant;

  // The ALU has a fixed one-cycle latency, so the tag only needs to live for
  // the cycle after the grant.
  always_comb begin
    tag_next.valid = |grant;
    tag_next.err   = (|grant) && mode_is_err(alu_mode);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_reg <= '0;
    end else begin
      tag_reg <= tag_next;
    end
  end

  // ALU results arriving without a tag are ignored.
  assign capture = tag_reg.valid && bus.alu_valid_i;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
      logic hit;
      assign hit = capture && (last_grant == IDW'(gi));

      // Capture has priority over the drain so a same-cycle refill keeps
      // the slot valid.
      always_ff @(posedge clk) begin
        if (rst) begin
          rsp_valid_reg[gi] <= 1'b0;
          rsp_err_reg[gi]   <= 1'b0;
          rsp_res_reg[gi]   <= '0;
        end else if (hit) begin
          rsp_valid_reg[gi] <= 1'b1;
          rsp_err_reg[gi]   <= tag_reg.err;
          rsp_res_reg[gi]   <= tag_reg.err ? '0 : bus.alu_res_i;
        end else if (rsp_valid_reg[gi] && bus.rsp_ready_i[gi]) begin
          rsp_valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_comb begin
    rsp_res_flat = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_res_flat[16*i +: 16] = rsp_res_reg[i];
    end
  end

  assign bus.rsp_valid_o = rsp_valid_reg;
  assign bus.rsp_err_o   = rsp_err_reg;
  assign bus.rsp_res_o   = rsp_res_flat;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
// Directed bench for alu_share_arbiter with NREQ=2 and a behavioural
// one-cycle fixed-point ALU. Inputs change on the falling edge, outputs are
// sampled 1 ns later; expected values are hand-computed constants.
module tb_alu_share_arbiter;

  localparam int NREQ = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic        alu_v;
  logic [15:0] alu_r;

  alu_share_arbiter_if #(.NREQ(NREQ)) bus ();

  alu_share_arbiter #(.NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: operands registered on the rising edge, result and valid
  // visible the following cycle. DIV returns a real quotient on purpose.
  function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] m);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    logic signed [15:0] r;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    case (m)
      3'd0:    r = sa + sb;
      3'd1:    r = sa - sb;
      3'd2:    r = sa * sb;
      3'd3:    r = (sb != 0) ? sa / sb : 16'sd0;
      3'd4:    r = sa <<< b;
      3'd5:    r = sa >>> b;
      default: r = 16'sd0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      alu_v <= 1'b0;
      alu_r <= 16'h0000;
    end else begin
      alu_v <= bus.alu_valid_o;
      alu_r <= alu_model(bus.alu_op1_o, bus.alu_op2_o, bus.alu_mode_o);
    end
  end

  assign bus.alu_valid_i = alu_v;
  assign bus.alu_res_i   = alu_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %-16s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %-16s val=%08h t=%0t", tag, got, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] m);
    bus.req_valid_i[i]       = v;
    bus.req_op1_i[8*i +: 8]  = a;
    bus.req_op2_i[8*i +: 8]  = b;
    bus.req_mode_i[3*i +: 3] = m;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.req_valid_i = '0;
    bus.req_op1_i   = '0;
    bus.req_op2_i   = '0;
    bus.req_mode_i  = '0;
    bus.rsp_ready_i = '0;

    // Reset state
    step(); step(); #1;
    check("rst_req_ready", 32'(bus.req_ready_o), 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
    check("rst_rsp_res",   32'(bus.rsp_res_o),   32'h0);
    check("rst_rsp_err",   32'(bus.rsp_err_o),   32'h0);
    check("rst_alu_valid", 32'(bus.alu_valid_o), 32'h0);
    check("rst_alu_ops",   {8'h0, bus.alu_op1_o, bus.alu_op2_o, 5'h0, bus.alu_mode_o}, 32'h0);
    step();
    rst = 1'b0;

    // Single ADD 5,3 from requester 0
    step(); set_req(0, 1'b1, 8'd5, 8'd3, 3'd0); #1;
    check("t1_grant",     32'(bus.req_ready_o), 32'h1);
    check("t1_alu_ops",   {bus.alu_op1_o, bus.alu_op2_o, 13'h0, bus.alu_mode_o}, 32'h0503_0000);
    check("t1_alu_valid", 32'(bus.alu_valid_o), 32'h1);
    step(); set_req(0, 1'b0, 8'd0, 8'd0, 3'd0); #1;
    check("t1_lat_t1",    32'(bus.rsp_valid_o), 32'h0);
    step(); #1;
    check("t1_valid_t2",  32'(bus.rsp_valid_o), 32'h1);
    check("t1_res",       32'(bus.rsp_res_o[15:0]), 32'h0008);
    check("t1_err",       32'(bus.rsp_err_o), 32'h0);
    step(); bus.rsp_ready_i = 2'b01;
    step(); bus.rsp_ready_i = 2'b00; #1;
    check("t1_consumed",  32'(bus.rsp_valid_o), 32'h0);

    // Both requesters continuously valid, alternating grants
    do_reset();
    set_req(0, 1'b1, 8'hFC, 8'd7, 3'd2);
    set_req(1, 1'b1, 8'd2,  8'd9, 3'd1);
    bus.rsp_ready_i = 2'b11; #1;
    check("t2_grant0", 32'(bus.req_ready_o), 32'h1);
    step(); #1;
    check("t2_grant1", 32'(bus.req_ready_o), 32'h2);
    step(); #1;
    check("t2_grant2", 32'(bus.req_ready_o), 32'h1);
    check("t2_res0",   32'(bus.rsp_res_o[15:0]), 32'hFFE4);
    step(); #1;
    check("t2_grant3", 32'(bus.req_ready_o), 32'h2);
    check("t2_res1",   32'(bus.rsp_res_o[31:16]), 32'hFFF9);
    step();
    set_req(0, 1'b0, 8'd0, 8'd0, 3'd0);
    set_req(1, 1'b0, 8'd0, 8'd0, 3'd0);
    step(); step(); step(); #1;
    check("t2_drained", 32'(bus.rsp_valid_o), 32'h0);

    // Held slot 0 blocks only requester 0
    step(); set_req(0, 1'b1, 8'd1, 8'd1, 3'd0); bus.rsp_ready_i = 2'b00; #1;
    check("t3_grant0", 32'(bus.req_ready_o), 32'h1);
    step(); set_req(1, 1'b1, 8'd3, 8'd2, 3'd4); bus.rsp_ready_i = 2'b10; #1;
    check("t3_block1", 32'(bus.req_ready_o), 32'h2);
    step(); set_req(1, 1'b0, 8'd0, 8'd0, 3'd0); #1;
    check("t3_block2", 32'(bus.req_ready_o), 32'h0);
    step(); #1;
    check("t3_block3", 32'(bus.req_ready_o), 32'h0);
    check("t3_res1",   32'(bus.rsp_res_o[31:16]), 32'h000C);
    check("t3_valid",  32'(bus.rsp_valid_o), 32'h3);
    step(); #1;
    check("t3_block4", 32'(bus.req_ready_o), 32'h0);
    step(); #1;
    check("t3_block5", 32'(bus.req_ready_o), 32'h0);
    check("t3_held0",  32'(bus.rsp_res_o[15:0]), 32'h0002);
    step(); bus.rsp_ready_i = 2'b11; #1;
    check("t3_release", 32'(bus.req_ready_o), 32'h1);
    step(); set_req(0, 1'b0, 8'd0, 8'd0, 3'd0);
    step(); step(); #1;
    check("t3_drained", 32'(bus.rsp_valid_o), 32'h0);

    // Unsupported mode (DIV) from requester 1
    step(); set_req(1, 1'b1, 8'd10, 8'd2, 3'd3); #1;
    check("t4_grant",    32'(bus.req_ready_o), 32'h2);
    check("t4_alu_mode", 32'(bus.alu_mode_o), 32'h3);
    step(); set_req(1, 1'b0, 8'd0, 8'd0, 3'd0); #1;
    check("t4_lat_t1",   32'(bus.rsp_valid_o), 32'h0);
    step(); #1;
    check("t4_valid_t2", 32'(bus.rsp_valid_o), 32'h2);
    check("t4_res",      32'(bus.rsp_res_o[31:16]), 32'h0000);
    check("t4_err",      32'(bus.rsp_err_o), 32'h2);
    step();

    // Reset the cycle after an accept
    step(); set_req(0, 1'b1, 8'd7, 8'd7, 3'd0); #1;
    check("t5_grant", 32'(bus.req_ready_o), 32'h1);
    step(); set_req(0, 1'b0, 8'd0, 8'd0, 3'd0); rst = 1'b1; #1;
    check("t5_rst_ready", 32'(bus.req_ready_o), 32'h0);
    check("t5_rst_alu",   32'(bus.alu_valid_o), 32'h0);
    step(); rst = 1'b0; #1;
    check("t5_no_rsp",   32'(bus.rsp_valid_o), 32'h0);
    check("t5_res_zero", 32'(bus.rsp_res_o), 32'h0);
    step(); #1;
    check("t5_no_rsp2",  32'(bus.rsp_valid_o), 32'h0);
    step();
    set_req(0, 1'b1, 8'd1, 8'd2, 3'd0);
    set_req(1, 1'b1, 8'd3, 8'd4, 3'd0); #1;
    check("t5_first", 32'(bus.req_ready_o), 32'h1);
    step();
    set_req(0, 1'b0, 8'd0, 8'd0, 3'd0);
    set_req(1, 1'b0, 8'd0, 8'd0, 3'd0);
    step(); step(); step();

    // SHIFTDOWN -16,2 held until consumed
    step(); set_req(0, 1'b1, 8'hF0, 8'd2, 3'd5); bus.rsp_ready_i = 2'b00; #1;
    check("t6_grant", 32'(bus.req_ready_o), 32'h1);
    step(); set_req(0, 1'b0, 8'd0, 8'd0, 3'd0);
    step(); #1;
    check("t6_valid", 32'(bus.rsp_valid_o), 32'h1);
    check("t6_res",   32'(bus.rsp_res_o[15:0]), 32'hFFFC);
    step(); #1;
    check("t6_hold1", 32'(bus.rsp_res_o[15:0]), 32'hFFFC);
    step(); #1;
    check("t6_hold2", {bus.rsp_res_o[15:0], 14'h0, bus.rsp_valid_o}, 32'hFFFC_0001);
    step(); bus.rsp_ready_i = 2'b01; #1;
    check("t6_take",  {bus.rsp_res_o[15:0], 14'h0, bus.rsp_valid_o}, 32'hFFFC_0001);
    step(); #1;
    check("t6_gone",  32'(bus.rsp_valid_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one `alu_fixed_point` instance between NREQ independent requesters. Each cycle it selects at most one pending request by round-robin, drives the ALU's operand and mode inputs, and tracks which requester owns each in-flight operation. It routes each ALU result into a per-requester response slot with valid/ready backpressure. It sits between the ALU and client blocks and is the only driver of the ALU inputs.

## Interface
- NREQ, 2: number of requesters, 2..8.
- clk  in  1: clock, rising edge.
- rst  in  1: synchronous, active-high reset.
- req_valid_i  in  NREQ: request pending per requester.
- req_ready_o  out  NREQ: request accepted this cycle, one-hot or zero.
- req_op1_i  in  8*NREQ: signed operand 1; requester i occupies bits [8i+7:8i].
- req_op2_i  in  8*NREQ: signed operand 2, same packing as req_op1_i.
- req_mode_i  in  3*NREQ: mode code; requester i occupies bits [3i+2:3i].
- rsp_valid_o  out  NREQ: response slot holds a result.
- rsp_ready_i  in  NREQ: requester consumes its response.
- rsp_res_o  out  16*NREQ: signed 16-bit result per slot.
- rsp_err_o  out  NREQ: the mode was unsupported (3, 6 or 7).
- alu_op1_o  out  8: ALU op1 input.
- alu_op2_o  out  8: ALU op2 input.
- alu_mode_o  out  3: ALU mode input.
- alu_valid_o  out  1: ALU valid input.
- alu_res_i  in  16: ALU result.
- alu_valid_i  in  1: ALU valid output.

## Operation
- Eligibility of requester i:
  - req_valid_i[i] is 1, and
  - no operation for i is in flight, and
  - the slot is free: rsp_valid_o[i]=0, or rsp_ready_i[i]=1 in this cycle.
- Grant:
  - Round-robin over eligible requesters, starting at last_grant+1 modulo NREQ.
  - last_grant resets to NREQ-1, so requester 0 has first priority.
  - last_grant updates only on a grant.
- req_ready_o is combinational and equals the grant vector.
- Requester obligations:
  - req_valid must not depend on req_ready.
  - The payload must stay stable while valid and not yet accepted.
- ALU drive on a grant:
  - alu_op1_o, alu_op2_o and alu_mode_o are muxed combinationally from the granted requester.
  - alu_valid_o is 1 on a grant.
  - With no grant, all ALU outputs are 0.
- In-flight tracking:
  - On a grant, register tag = {1'b1, id, err}.
  - err = mode ∉ {0,1,2,4,5}.
- Capture, in the cycle where the tag is valid and alu_valid_i is 1:
  - Write the slot for tag id: rsp_res = err ? 0 : alu_res_i, and rsp_err = err.
  - Set rsp_valid for that slot.
- alu_valid_i while the tag is invalid is ignored.
- A slot clears on rsp_valid & rsp_ready. A clear and a new capture to the same slot in the same cycle results in capture (valid stays 1).
- Arithmetic: values pass through unchanged; the ALU defines the results (sign-extended 16-bit add, sub and mult; arithmetic shifts).

## Timing
- Reset values: every output is 0, tag invalid, last_grant = NREQ-1.
- Latency: accept in cycle t, ALU registers the operands at the t→t+1 edge, the slot captures at the t+1→t+2 edge, and rsp_valid_o is 1 from cycle t+2.
- Throughput:
  - One grant per cycle in aggregate.
  - Each requester has at most one operation in flight, so each requester gets at most one grant per 2 cycles.
- A held slot (rsp_valid=1, rsp_ready=0) blocks only its own requester. Other requesters keep being granted.
- Reset during operation: in-flight tag and slots are dropped. No response appears for an operation accepted before the reset. The ALU shares rst.
- A requester that deasserts valid before acceptance loses its turn without side effects.

## Structure
- Shared header (projectGlobalParam.v):
  - mode localparams ADD=0, SUB=1, MULT=2, DIV=3, SHIFTUP=4, SHIFTDOWN=5;
  - operand width 8 and result width 16;
  - reset value/polarity macros.
- Sub-module rr_arbiter:
  - parameter NREQ;
  - inputs: eligible vector and an advance strobe;
  - outputs: one-hot grant and the last_grant register.
- The top level holds the tag register, the payload mux and the response slots.

## Test plan
- Req0 sends ADD 5,3 alone and is accepted in cycle t. Expect rsp_valid_o[0]=1 at t+2, res=0x0008, err=0. Nothing on req1.
- Both requesters are continuously valid and rsp_ready=11. Expect grants 0,1,0,1. Req0 MULT -4,7 returns 0xFFE4; req1 SUB 2,9 returns 0xFFF9.
- rsp_ready_i[0]=0 with slot 0 full. Expect req_ready_o[0]=0 for 5 cycles while req1 SHIFTUP 3,2 completes with 0x000C. Releasing ready gives req0 the next grant.
- Req1 sends DIV 10,2 (mode 3). Expect res=0x0000, err=1, latency 2.
- rst pulses in cycle t+1 after an accept at t. Expect no rsp_valid and all outputs 0. The first grant after reset goes to requester 0 when both are valid.
- Req0 sends SHIFTDOWN -16,2 and deasserts rsp_ready for 3 cycles. Expect 0xFFFC held stable until consumed.
